// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pkg
//  Description : Shared definitions for the SR flip-flop bank controller:
//                FSM state encodings, operation codes, default retry count
//                and a small width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

  // Controller FSM states; encodings are fixed so they read the same in
  // waveforms and in any software that inspects the state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  // Per-requester operation codes
  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  // Re-drive attempts after a failed check
  localparam int DEFAULT_MAX_RETRY = 2;

  // Bit width needed to hold values 0..n-1, never less than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : sr_pkg
`default_nettype wire

// File: rtl/sr_bank_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first
//                requesting index at or after ptr, wrapping around.
//  Ports       : req    in  NREQ  request vector
//                ptr    in  IDW   search start index
//                win    out NREQ  one-hot winner (all zero if no request)
//                win_id out IDW   index of the winner (0 if no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sr_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]               req,
  input  logic [clog2_min1(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]               win,
  output logic [clog2_min1(NREQ)-1:0]   win_id
);

  localparam int IDW = clog2_min1(NREQ);

  logic found;
  int   cand;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sr_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sr_bank_ctrl
//  Description : Shares one external bank of SR flip-flops among NREQ
//                requesters. Arbitrates round-robin, turns each granted
//                set/clear into a one-cycle S or R pulse on the addressed
//                bit, verifies the bank Q feedback, retries up to MAX_RETRY
//                times and reports done or err. S and R are never driven
//                together and at most one bit is driven at a time.
//  Ports       : clk     in  1          clock, rising edge
//                rst     in  1          asynchronous active-high reset
//                req     in  NREQ       request levels, held until granted
//                op      in  NREQ       1 = set, 0 = clear
//                idx     in  NREQ*IDXW  bit index, slice [i*IDXW +: IDXW]
//                q_in    in  NBITS      Q feedback from the bank
//                gnt     out NREQ       one-hot grant pulse
//                gnt_id  out log2 NREQ  current/last grantee
//                s_out   out NBITS      S drive to the bank
//                r_out   out NBITS      R drive to the bank
//                busy    out 1          FSM not in IDLE
//                done    out 1          operation verified (pulse)
//                err     out 1          operation failed / illegal index
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_ctrl
  import sr_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NBITS     = 8,
  parameter int IDXW      = 3,
  parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               op,
  input  logic [NREQ*IDXW-1:0]          idx,
  input  logic [NBITS-1:0]              q_in,
  output logic [NREQ-1:0]               gnt,
  output logic [clog2_min1(NREQ)-1:0]   gnt_id,
  output logic [NBITS-1:0]              s_out,
  output logic [NBITS-1:0]              r_out,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int IDW = clog2_min1(NREQ);
  localparam int RW  = clog2_min1(MAX_RETRY + 1);

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [RW-1:0]     retry_cnt;
  logic              op_r;
  logic [IDXW-1:0]   idx_r;

  logic [NREQ-1:0]   win;
  logic [IDW-1:0]    win_id;
  logic [IDXW-1:0]   win_idx;
  logic              win_op;
  logic [IDW-1:0]    ptr_next;
  logic [NBITS-1:0]  bit_mask;
  logic              idx_ok;
  logic              q_ok;
  logic              retry_ok;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id)
  );

  always_comb begin
    win_idx  = idx[int'(win_id)*IDXW +: IDXW];
    win_op   = op[win_id];
    ptr_next = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    // One-hot of the captured index; zero when the index is beyond the
    // bank, so an illegal index can never reach the drive or check logic.
    bit_mask = NBITS'(1) << idx_r;
    idx_ok   = int'(idx_r) < NBITS;
    q_ok     = ((|(q_in & bit_mask)) == op_r);
    retry_ok = int'(retry_cnt) < MAX_RETRY;
  end

  // Single FSM process. Pulse outputs default low every cycle, so gnt,
  // s_out, r_out, done and err are high for exactly the cycle they are
  // registered in. Asynchronous reset drops the bank drive immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      retry_cnt <= '0;
      op_r      <= OP_CLR;
      idx_r     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      s_out     <= '0;
      r_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      gnt   <= '0;
      s_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Grant, operand capture and pointer update are registered
          // together so the GRANT cycle carries gnt and the operands.
          if (|req) begin
            state     <= ST_GRANT;
            busy      <= 1'b1;
            gnt       <= win;
            gnt_id    <= win_id;
            op_r      <= win_op;
            idx_r     <= win_idx;
            ptr       <= ptr_next;
            retry_cnt <= '0;
          end
        end

        ST_GRANT: begin
          if (!idx_ok) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (op_r == OP_SET) s_out <= bit_mask;
            else                r_out <= bit_mask;
            state <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (q_ok) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (retry_ok) begin
            retry_cnt <= retry_cnt + RW'(1);
            if (op_r == OP_SET) s_out <= bit_mask;
            else                r_out <= bit_mask;
            state <= ST_DRIVE;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : sr_bank_ctrl
`default_nettype wire

// File: tb/tb_sr_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_bank_ctrl
//  Description : Self-checking bench for sr_bank_ctrl. An 8-bit DUT talks to
//                a behavioural SR bank (with per-bit stuck-at-0 forcing); a
//                second 6-bit DUT exercises the illegal-index path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, op;
  logic [11:0] idx;
  logic [7:0]  q_in;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  s_out, r_out;
  logic        busy, done, err;

  logic [3:0]  req6, op6;
  logic [11:0] idx6;
  logic [5:0]  q6;
  logic [3:0]  gnt6;
  logic [1:0]  gnt_id6;
  logic [5:0]  s6, r6;
  logic        busy6, done6, err6;

  logic [7:0]  bank_q;
  logic [7:0]  force0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_bank_ctrl #(.NREQ(4), .NBITS(8), .IDXW(3), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .q_in(q_in),
    .gnt(gnt), .gnt_id(gnt_id), .s_out(s_out), .r_out(r_out),
    .busy(busy), .done(done), .err(err)
  );

  sr_bank_ctrl #(.NREQ(4), .NBITS(6), .IDXW(3), .MAX_RETRY(2)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6), .q_in(q6),
    .gnt(gnt6), .gnt_id(gnt_id6), .s_out(s6), .r_out(r6),
    .busy(busy6), .done(done6), .err(err6)
  );

  // Behavioural SR bank; force0 pins selected Q outputs low
  always @(posedge clk or posedge rst) begin
    if (rst) bank_q <= 8'h00;
    else     bank_q <= (bank_q | s_out) & ~r_out;
  end
  assign q_in = bank_q & ~force0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Continuous invariants on both DUTs
  always @(negedge clk) begin
    checks++;
    if ((s_out & r_out) != 0 || $countones(s_out | r_out) > 1 || (done && err) ||
        (s6 & r6) != 0 || $countones(s6 | r6) > 1 || (done6 && err6)) begin
      errors++;
      $display("FAIL invariant: s=%h r=%h done=%b err=%b s6=%h r6=%h done6=%b err6=%b expected disjoint single-bit drive, no done+err",
               s_out, r_out, done, err, s6, r6, done6, err6);
    end
  end

  typedef struct {
    int         rid;
    logic       o;
    logic [2:0] b;
    logic [3:0] eg;
    logic [7:0] es;
    logic [7:0] er;
    logic [7:0] eq;
  } vec_t;

  vec_t vt[6];

  // One isolated request, called at a negedge with the DUT idle.
  // Captures gnt/gnt_id at k+1, drive and busy at k+2, done/err at k+5.
  task automatic do_single(input int rid, input logic o, input logic [2:0] b,
                           output logic [3:0] g1, output logic [1:0] id1,
                           output logic [7:0] s2, output logic [7:0] r2,
                           output logic bz2, output logic d5, output logic e5);
    req[rid]          = 1'b1;
    op[rid]           = o;
    idx[rid*3 +: 3]   = b;
    @(posedge clk);
    @(negedge clk); g1 = gnt; id1 = gnt_id; req[rid] = 1'b0;
    @(negedge clk); s2 = s_out; r2 = r_out; bz2 = busy;
    repeat (3) @(negedge clk);
    d5 = done; e5 = err;
  endtask

  logic [3:0]  g1;
  logic [1:0]  id1;
  logic [7:0]  s2, r2;
  logic        bz2, d5, e5;
  logic [15:0] drv_seen, done_seen, err_seen;
  logic        any_de, any_busy, any_drv6;
  int          order[5];
  logic [7:0]  es4[4];
  logic [7:0]  er4[4];
  int          gcount, dcount, last_id;
  logic        pend;

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0; force0 = '0;
    req6 = '0; op6 = '0; idx6 = '0; q6 = '0;

    vt[0] = '{0, 1'b1, 3'd5, 4'b0001, 8'h20, 8'h00, 8'h20};
    vt[1] = '{1, 1'b1, 3'd0, 4'b0010, 8'h01, 8'h00, 8'h21};
    vt[2] = '{2, 1'b0, 3'd5, 4'b0100, 8'h00, 8'h20, 8'h01};
    vt[3] = '{3, 1'b1, 3'd7, 4'b1000, 8'h80, 8'h00, 8'h81};
    vt[4] = '{0, 1'b0, 3'd0, 4'b0001, 8'h00, 8'h01, 8'h80};
    vt[5] = '{1, 1'b0, 3'd3, 4'b0010, 8'h00, 8'h08, 8'h80};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt",    32'(gnt),    32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_s",      32'(s_out),  32'h0);
    chk("rst_r",      32'(r_out),  32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_err",    32'(err),    32'h0);

    // Table-driven single operations through the real SR bank
    for (int i = 0; i < 6; i++) begin
      do_single(vt[i].rid, vt[i].o, vt[i].b, g1, id1, s2, r2, bz2, d5, e5);
      chk($sformatf("vec%0d_gnt", i),    32'(g1),  32'(vt[i].eg));
      chk($sformatf("vec%0d_gnt_id", i), 32'(id1), 32'(vt[i].rid));
      chk($sformatf("vec%0d_s", i),      32'(s2),  32'(vt[i].es));
      chk($sformatf("vec%0d_r", i),      32'(r2),  32'(vt[i].er));
      chk($sformatf("vec%0d_busy", i),   32'(bz2), 32'h1);
      chk($sformatf("vec%0d_done", i),   32'(d5),  32'h1);
      chk($sformatf("vec%0d_err", i),    32'(e5),  32'h0);
      chk($sformatf("vec%0d_q", i),      32'(q_in), 32'(vt[i].eq));
    end

    // Stuck-at-0 bit 2: drives at k+2,k+5,k+8, err at k+11, no done
    force0 = 8'h04;
    drv_seen = '0; done_seen = '0; err_seen = '0;
    req[0] = 1'b1; op[0] = 1'b1; idx[2:0] = 3'd2;
    @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) req[0] = 1'b0;
      if (s_out != 0 || r_out != 0) drv_seen[n] = 1'b1;
      if (done) done_seen[n] = 1'b1;
      if (err)  err_seen[n]  = 1'b1;
    end
    chk("stuck_drives", 32'(drv_seen),  32'h0124);
    chk("stuck_err",    32'(err_seen),  32'h0800);
    chk("stuck_done",   32'(done_seen), 32'h0000);
    chk("stuck_busy",   32'(busy),      32'h0);
    force0 = 8'h00;

    // Recovery: first check on bit 6 fails, retry passes, done at k+8
    force0 = 8'h40;
    drv_seen = '0; done_seen = '0; err_seen = '0;
    req[1] = 1'b1; op[1] = 1'b1; idx[5:3] = 3'd6;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) req[1] = 1'b0;
      if (n == 5) force0 = 8'h00;
      if (s_out != 0 || r_out != 0) drv_seen[n] = 1'b1;
      if (done) done_seen[n] = 1'b1;
      if (err)  err_seen[n]  = 1'b1;
    end
    chk("recov_drives", 32'(drv_seen),  32'h0024);
    chk("recov_done",   32'(done_seen), 32'h0100);
    chk("recov_err",    32'(err_seen),  32'h0000);

    // Illegal index 7 on the 6-bit bank: gnt at k+1, err at k+2, no drive
    done_seen = '0; err_seen = '0; any_drv6 = 1'b0;
    req6[0] = 1'b1; op6[0] = 1'b1; idx6[2:0] = 3'd7;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("illegal_gnt", 32'(gnt6), 32'h1);
        req6[0] = 1'b0;
      end
      if (s6 != 0 || r6 != 0) any_drv6 = 1'b1;
      if (done6) done_seen[n] = 1'b1;
      if (err6)  err_seen[n]  = 1'b1;
    end
    chk("illegal_err",   32'(err_seen),  32'h0004);
    chk("illegal_done",  32'(done_seen), 32'h0000);
    chk("illegal_drive", 32'(any_drv6),  32'h0);
    chk("illegal_busy",  32'(busy6),     32'h0);

    // Reset during DRIVE: drive vanishes at once, nothing reported after
    req[2] = 1'b1; op[2] = 1'b1; idx[8:6] = 3'd1;
    @(posedge clk);
    @(negedge clk); req[2] = 1'b0;
    @(negedge clk);
    chk("midrst_drive", 32'(s_out), 32'h02);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_async",    32'(s_out), 32'h0);
    chk("midrst_busy_async", 32'(busy),  32'h0);
    @(negedge clk); rst = 1'b0;
    any_de = 1'b0; any_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || err) any_de = 1'b1;
      if (busy) any_busy = 1'b1;
    end
    chk("midrst_no_done_err", 32'(any_de),   32'h0);
    chk("midrst_busy",        32'(any_busy), 32'h0);

    // All four requesting continuously; pointer restarts at 0 after reset
    order = '{0, 1, 2, 3, 0};
    es4   = '{8'h00, 8'h04, 8'h00, 8'h10};
    er4   = '{8'h02, 8'h00, 8'h08, 8'h00};
    op    = 4'b1010;
    idx   = {3'd4, 3'd3, 3'd2, 3'd1};
    req   = 4'b1111;
    gcount = 0; dcount = 0; pend = 1'b0; last_id = 0;
    @(posedge clk);
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (pend) begin
        chk($sformatf("rr_s_%0d", gcount), 32'(s_out), 32'(es4[last_id]));
        chk($sformatf("rr_r_%0d", gcount), 32'(r_out), 32'(er4[last_id]));
        pend = 1'b0;
      end
      if (gnt != 0) begin
        if (gcount < 5) begin
          chk($sformatf("rr_gnt_%0d", gcount), 32'(gnt), 32'(4'b0001 << order[gcount]));
          last_id = order[gcount];
          pend = 1'b1;
        end
        gcount++;
      end
      if (done) dcount++;
    end
    req = 4'b0000;
    chk("rr_grant_count", 32'(gcount), 32'd5);
    chk("rr_done_count",  32'(dcount), 32'd5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sr_bank_ctrl
`default_nettype wire
